// File: rtl/tune_pkg.sv
// Shared types and constants for the melody sequencer.
// Note codes, half-period table, FSM states, ROM entry layout.
package tune_pkg;

  typedef enum logic [2:0] {
    REST, A4, B4, C5, D5, E5, F5, G5
  } note_e;

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, PLAY, GAP
  } state_e;

  localparam int NOTE_W  = 3;
  localparam int DUR_W   = 5;
  localparam int ENTRY_W = NOTE_W + DUR_W;

  localparam logic [ENTRY_W-1:0] END_MARK = '0;

  // 25 MHz / f / 2, truncated
  localparam logic [15:0] HP_A4 = 16'd28409;
  localparam logic [15:0] HP_B4 = 16'd25303;
  localparam logic [15:0] HP_C5 = 16'd23900;
  localparam logic [15:0] HP_D5 = 16'd21294;
  localparam logic [15:0] HP_E5 = 16'd18968;
  localparam logic [15:0] HP_F5 = 16'd17908;
  localparam logic [15:0] HP_G5 = 16'd15964;

  function automatic logic [15:0] note_period(input note_e n);
    logic [15:0] p;
    p = 16'd0;
    case (n)
      A4:      p = HP_A4;
      B4:      p = HP_B4;
      C5:      p = HP_C5;
      D5:      p = HP_D5;
      E5:      p = HP_E5;
      F5:      p = HP_F5;
      G5:      p = HP_G5;
      default: p = 16'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody storage, one entry per address.
// Synchronous read, data valid one cycle after addr.
module melody_rom
  import tune_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter logic [DEPTH*ENTRY_W-1:0] INIT = '0
) (
  input  logic                 clk_25mhz,
  input  logic [AW-1:0]        addr,
  output logic [ENTRY_W-1:0]   data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Unpack the flat contents; entry i sits at bits [8i +: 8]
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = INIT[i*ENTRY_W +: ENTRY_W];
    end
  end

  // Registered read port
  always_ff @(posedge clk_25mhz) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/tune_sequencer.sv
// Melody sequencer and key arbiter for the tone generator.
// Held keys preempt the melody, which freezes and resumes.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int BEAT_CYCLES = 3125000,
  parameter int GAP_CYCLES  = 250000,
  parameter int ROM_DEPTH   = 32,
  parameter logic [ROM_DEPTH*ENTRY_W-1:0] ROM_INIT =
    {{(ROM_DEPTH-4){8'h00}}, 8'h01, 8'hA2, 8'h81, 8'h61}
) (
  input  logic                         clk_25mhz,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         loop,
  input  logic [6:0]                   keys,
  output logic [15:0]                  half_period,
  output logic                         tone_en,
  output logic                         source,
  output logic                         busy,
  output logic [$clog2(ROM_DEPTH)-1:0] pos
);

  localparam int AW = $clog2(ROM_DEPTH);
  localparam int BW = $clog2(BEAT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e           state, state_n;
  note_e            note, note_n, key_note;
  logic [AW-1:0]    pos_n;
  logic [DUR_W-1:0] dur_left, dur_n;
  logic [BW-1:0]    beat_cnt, beat_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic [ENTRY_W-1:0] rom_data;
  logic [15:0]      hp_n;
  logic             ten_n, src_n, busy_n, key_any;

  melody_rom #(
    .DEPTH (ROM_DEPTH),
    .AW    (AW),
    .INIT  (ROM_INIT)
  ) u_rom (
    .clk_25mhz (clk_25mhz),
    .addr      (pos),
    .data      (rom_data)
  );

  // Highest-index pressed key wins; keys[i] maps to note 7-i
  always_comb begin
    key_note = REST;
    for (int i = 0; i < 7; i++) begin
      if (keys[i]) key_note = note_e'(3'(7 - i));
    end
  end

  assign key_any = |keys;

  // State, counters and registered outputs
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state       <= IDLE;
      note        <= REST;
      pos         <= '0;
      dur_left    <= '0;
      beat_cnt    <= '0;
      gap_cnt     <= '0;
      half_period <= '0;
      tone_en     <= 1'b0;
      source      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      note        <= note_n;
      pos         <= pos_n;
      dur_left    <= dur_n;
      beat_cnt    <= beat_n;
      gap_cnt     <= gap_n;
      half_period <= hp_n;
      tone_en     <= ten_n;
      source      <= src_n;
      busy        <= busy_n;
    end
  end

  // Next state; a held key freezes everything except stop
  always_comb begin
    state_n = state;
    note_n  = note;
    pos_n   = pos;
    dur_n   = dur_left;
    beat_n  = beat_cnt;
    gap_n   = gap_cnt;
    if (stop) begin
      state_n = IDLE;
      pos_n   = '0;
    end else if (!key_any) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = FETCH;
            pos_n   = '0;
          end
        end
        FETCH: state_n = LOAD;
        LOAD: begin
          if (rom_data == END_MARK) begin
            if (loop) begin
              pos_n   = '0;
              state_n = FETCH;
            end else begin
              state_n = IDLE;
            end
          end else begin
            note_n  = note_e'(rom_data[ENTRY_W-1 -: NOTE_W]);
            dur_n   = rom_data[DUR_W-1:0];
            if (dur_n == '0) dur_n = DUR_W'(1);
            beat_n  = BW'(BEAT_CYCLES - 1);
            state_n = PLAY;
          end
        end
        PLAY: begin
          if (beat_cnt == '0) begin
            beat_n = BW'(BEAT_CYCLES - 1);
            dur_n  = dur_left - DUR_W'(1);
            if (dur_left == DUR_W'(1)) begin
              gap_n   = GW'(GAP_CYCLES - 1);
              state_n = GAP;
            end
          end else begin
            beat_n = beat_cnt - BW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            pos_n   = pos + AW'(1);
            state_n = FETCH;
          end else begin
            gap_n = gap_cnt - GW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Output values for the next cycle; silence holds the period
  always_comb begin
    hp_n   = half_period;
    ten_n  = 1'b0;
    src_n  = key_any;
    busy_n = (state_n != IDLE);
    if (key_any) begin
      ten_n = 1'b1;
      hp_n  = note_period(key_note);
    end else if (state_n == PLAY && note_n != REST) begin
      ten_n = 1'b1;
      hp_n  = note_period(note_n);
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer.
// Three instances with different melody contents.
module tb_tune_sequencer;

  logic       clk_25mhz = 1'b0;
  logic       reset, stop, loop;
  logic [6:0] keys;
  logic       start [3];
  logic [15:0] hp   [3];
  logic       ten  [3];
  logic       src  [3];
  logic       busy [3];
  logic [4:0] pos  [3];

  int ntot  = 0;
  int npass = 0;
  int n;
  logic silent;

  always #20 clk_25mhz = ~clk_25mhz;

  tune_sequencer #(
    .BEAT_CYCLES (10), .GAP_CYCLES (3), .ROM_DEPTH (32),
    .ROM_INIT    (256'h22)
  ) u1 (
    .clk_25mhz (clk_25mhz), .reset (reset), .start (start[0]),
    .stop (stop), .loop (loop), .keys (keys),
    .half_period (hp[0]), .tone_en (ten[0]), .source (src[0]),
    .busy (busy[0]), .pos (pos[0])
  );

  tune_sequencer #(
    .BEAT_CYCLES (10), .GAP_CYCLES (3), .ROM_DEPTH (32),
    .ROM_INIT    (256'h6103)
  ) u2 (
    .clk_25mhz (clk_25mhz), .reset (reset), .start (start[1]),
    .stop (stop), .loop (loop), .keys (keys),
    .half_period (hp[1]), .tone_en (ten[1]), .source (src[1]),
    .busy (busy[1]), .pos (pos[1])
  );

  tune_sequencer #(
    .BEAT_CYCLES (10), .GAP_CYCLES (3), .ROM_DEPTH (32),
    .ROM_INIT    (256'hE0)
  ) u3 (
    .clk_25mhz (clk_25mhz), .reset (reset), .start (start[2]),
    .stop (stop), .loop (loop), .keys (keys),
    .half_period (hp[2]), .tone_en (ten[2]), .source (src[2]),
    .busy (busy[2]), .pos (pos[2])
  );

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; loop = 1'b0; keys = '0;
    start[0] = 1'b0; start[1] = 1'b0; start[2] = 1'b0;
    ticks(3);
    chk("rst_hp",   hp[0],   0);
    chk("rst_ten",  ten[0],  0);
    chk("rst_src",  src[0],  0);
    chk("rst_busy", busy[0], 0);
    chk("rst_pos",  pos[0],  0);
    reset = 1'b0;
    tick();

    // A4 two beats, then end marker
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk("a4_fetch_busy", busy[0], 1);
    chk("a4_fetch_ten",  ten[0],  0);
    ticks(2);
    chk("a4_ten", ten[0], 1);
    chk("a4_hp",  hp[0],  28409);
    n = 0;
    while (ten[0] === 1'b1 && n < 100) begin n++; tick(); end
    chk("a4_len", n, 20);
    n = 0; silent = 1'b1;
    while (busy[0] === 1'b1 && n < 50) begin
      if (ten[0] !== 1'b0) silent = 1'b0;
      n++; tick();
    end
    chk("a4_tail_cycles", n, 5);
    chk("a4_tail_silent", silent, 1);
    chk("a4_end_pos", pos[0], 1);

    // Rest 3 beats, then C5 1 beat; stop in the C5 gap
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    n = 1;
    while (ten[1] !== 1'b1 && n < 100) begin tick(); n++; end
    chk("rest_delay", n, 38);
    chk("c5_hp",   hp[1],   23900);
    chk("c5_pos",  pos[1],  1);
    n = 0;
    while (ten[1] === 1'b1 && n < 100) begin n++; tick(); end
    chk("c5_len",  n, 10);
    chk("c5_gap_busy", busy[1], 1);
    chk("c5_hold_hp",  hp[1],   23900);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("gap_stop_busy", busy[1], 0);
    chk("gap_stop_pos",  pos[1],  0);
    chk("gap_stop_ten",  ten[1],  0);

    // Key preemption mid-note
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    ticks(2);
    chk("key_pre_ten", ten[0], 1);
    ticks(4);
    keys = 7'b0000101;
    tick();
    chk("key_src", src[0], 1);
    chk("key_hp",  hp[0],  18968);
    chk("key_ten", ten[0], 1);
    chk("key_idle_src",  src[1],  1);
    chk("key_idle_busy", busy[1], 0);
    ticks(6);
    keys = '0;
    chk("key_held_src", src[0], 1);
    chk("key_held_pos", pos[0], 0);
    tick();
    chk("rel_src", src[0], 0);
    chk("rel_hp",  hp[0],  28409);
    chk("rel_ten", ten[0], 1);
    n = 0;
    while (ten[0] === 1'b1 && n < 100) begin n++; tick(); end
    chk("rel_remaining", n, 15);
    chk("rel_pos", pos[0], 0);
    n = 0;
    while (busy[0] === 1'b1 && n < 50) begin n++; tick(); end
    chk("rel_done", busy[0], 0);

    // Loop with G5 duration 0 then end marker
    loop = 1'b1;
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    ticks(2);
    chk("g5_hp",  hp[2],  15964);
    chk("g5_ten", ten[2], 1);
    n = 0;
    while (ten[2] === 1'b1 && n < 100) begin n++; tick(); end
    chk("g5_len", n, 10);
    ticks(3);
    chk("loop_pos1", pos[2], 1);
    ticks(2);
    chk("loop_pos0",  pos[2],  0);
    chk("loop_busy",  busy[2], 1);
    ticks(2);
    chk("loop_replay", ten[2], 1);
    ticks(10);
    chk("loop_gap_ten",  ten[2],  0);
    chk("loop_gap_busy", busy[2], 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("loop_stop_busy", busy[2], 0);
    ticks(3);
    chk("loop_stop_stays", busy[2], 0);
    loop = 1'b0;

    // start and stop together
    start[0] = 1'b1; stop = 1'b1; tick();
    start[0] = 1'b0; stop = 1'b0;
    chk("ss_busy", busy[0], 0);
    tick();
    chk("ss_busy2", busy[0], 0);
    chk("ss_ten",   ten[0],  0);

    // Reset during C5 play
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    ticks(39);
    chk("pre_rst_hp",  hp[1],  23900);
    chk("pre_rst_pos", pos[1], 1);
    keys = 7'b1000000; reset = 1'b1;
    tick();
    chk("mid_rst_hp",   hp[1],   0);
    chk("mid_rst_ten",  ten[1],  0);
    chk("mid_rst_src",  src[1],  0);
    chk("mid_rst_busy", busy[1], 0);
    chk("mid_rst_pos",  pos[1],  0);
    keys = '0; reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/tune_sequencer.md
# tune_sequencer

Controller for the square-wave tone generator on the audio path. Plays a melody stored in a small ROM by driving the generator's half-period reload value and enable, beat by beat. Also arbitrates generator ownership between the melody and the seven note keys: a held key preempts the melody, which pauses and then resumes where it stopped.

## Interface
Parameters:
- BEAT_CYCLES, 3125000: clock cycles per beat (8 beats/s at 25 MHz).
- GAP_CYCLES, 250000: silent articulation gap after every note (10 ms).
- ROM_DEPTH, 32: melody entries; address width is clog2(ROM_DEPTH) = 5.

Ports:
- clk_25mhz  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; starts the melody from address 0 when idle.
- stop  in  1  one-cycle pulse; aborts the melody.
- loop  in  1  level; when 1, the end marker restarts the melody at address 0.
- keys  in  7  note keys; keys[6]=A4 … keys[0]=G5; keys[6] has the highest priority.
- half_period  out  16  reload count for the generator; the generator toggles every half_period cycles.
- tone_en  out  1  1 = generator runs; 0 = output silent.
- source  out  1  1 = keys own the generator; 0 = sequencer owns it.
- busy  out  1  melody is active, including while paused.
- pos  out  5  current ROM address.

## Operation
- ROM entry is 8 bits: [7:5] note code (0 = rest, 1..7 = A4,B4,C5,D5,E5,F5,G5), [4:0] duration in beats.
- The entry 8'h00 is the end marker. A non-rest entry with duration 0 plays for 1 beat. A rest with duration ≥ 1 is silent (tone_en=0) for that many beats.
- Half-period constants are computed as 25000000/f/2 with integer division: A4 28409, B4 25303, C5 23900, D5 21294, E5 18968, F5 17908, G5 15964.
- States:
  - IDLE: busy=0. On start (and no stop in the same cycle), set pos=0 and go to FETCH.
  - FETCH: present address pos to the ROM (1 cycle), then go to LOAD.
  - LOAD: ROM data is valid.
    - End marker with loop=1: pos=0, go to FETCH.
    - End marker with loop=0: go to IDLE.
    - Otherwise: latch the note, set dur_left=max(dur,1), beat_cnt=BEAT_CYCLES-1, go to PLAY.
  - PLAY: tone_en=(note≠0). beat_cnt decrements each cycle. When beat_cnt wraps from 0, dur_left decrements. When dur_left reaches 0 at a wrap, set gap_cnt=GAP_CYCLES-1 and go to GAP.
  - GAP: tone_en=0. When gap_cnt reaches 0: pos=pos+1 (wraps modulo ROM_DEPTH), go to FETCH.
- Arbitration: while any keys bit is 1:
  - source=1, tone_en=1, half_period = period of the highest-priority pressed key.
  - State, pos, beat_cnt, dur_left and gap_cnt are all frozen. The melody resumes exactly in the cycle after the keys are released.
  - Keys work in IDLE too; busy is unaffected.
- stop: from any state go to IDLE with pos=0, tone_en=0 (unless a key is held). stop wins over a simultaneous start. A start while busy=1 is ignored.
- While the sequencer owns the generator and is silent, half_period holds its last value.

## Timing
- Reset values: half_period=0, tone_en=0, source=0, busy=0, pos=0, state IDLE, all counters 0.
- All outputs are registered; any input change appears on the outputs 1 cycle later.
- From a start pulse in cycle t: FETCH at t+1, LOAD at t+2, tone_en=1 and the new half_period visible at t+3.
- A note of d beats holds tone_en=1 for exactly d·BEAT_CYCLES cycles. The gap then holds tone_en=0 for GAP_CYCLES cycles. The sequencing overhead is 2 cycles (FETCH+LOAD) per entry.
- Key press at t: source=1 at t+1. Release at t+r: source=0 at t+r+1, and the melody counters resume counting in that same cycle.
- reset asserted mid-note: all outputs return to their reset values on the next edge.

## Structure
- Package tune_pkg holds:
  - the note code enum (REST, A4..G5);
  - the 7 half-period constants and a note-to-period function;
  - the state enum (IDLE, FETCH, LOAD, PLAY, GAP);
  - the ROM entry field widths.
- Sub-module melody_rom: synchronous read with 1-cycle latency, ROM_DEPTH×8, contents from an init file.
- Key priority encoding and the counters stay in the top module.

## Test plan
- Use a small configuration for simulation: BEAT_CYCLES=10, GAP_CYCLES=3.
- ROM {8'h22 (A4,2 beats), 8'h00}, start pulse → half_period=28409, tone_en=1 for 20 cycles, tone_en=0 for 3 cycles, then busy=0.
- Rest entry 8'h03 then C5 1 beat, start → tone_en=0 for 30+3 cycles, then half_period=23900 for 10 cycles.
- Mid-note: keys=7'b0000101 for 7 cycles → half_period=18968 (E5), source=1. After release the melody tone resumes, and the note's total PLAY time is still 20 cycles with no pos change.
- loop=1 with a 2-entry ROM → pos sequence 0,1,0,1…, and busy stays 1.
- start and stop in the same cycle → stays in IDLE. stop mid-GAP → IDLE, pos=0. reset mid-PLAY → all outputs 0 on the next edge.
- Entry 8'hE0 (G5, duration 0) → plays 10 cycles at half_period=15964.
